// File: rtl/sap_pkg.sv
// Shared definitions for the SAP core: opcodes, FSM states, field widths.
package sap_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_F1   = 3'd0,
    ST_F2   = 3'd1,
    ST_E1   = 3'd2,
    ST_E2   = 3'd3,
    ST_E3   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

endpackage

// File: rtl/sap_ram.sv
// Program/data RAM: one synchronous write port, one combinational read port.
// Contents have no reset so a loaded program survives clr.
module sap_ram #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Synchronous write
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_core.sv
// SAP-1 style accumulator CPU with variable-length instruction cycles.
// Each instruction runs F1/F2 (fetch) then E1..E3 as needed and returns to F1
// as soon as it is done. out/out_valid are registered: out_valid is high in
// the cycle in which out first shows the newly written value.
module sap_core
  import sap_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WIDTH-1:0]  prog_data,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              halted,
  output logic [WIDTH-1:0]  bus
);

  if (WIDTH < OPCODE_W + ADDR_W) begin : g_bad_width
    $error("sap_core: WIDTH must be at least 4 + ADDR_W");
  end

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, mar;
  logic [WIDTH-1:0]  ir, a, b;
  logic              z, c;

  opcode_t           opcode;
  logic [ADDR_W-1:0] operand;
  logic [WIDTH-1:0]  operand_ext;
  logic [WIDTH-1:0]  ram_rdata;

  logic [WIDTH:0]    alu_sum, alu_diff;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_carry;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [WIDTH-1:0]  ram_wdata;
  logic              sta_write;

  assign opcode      = opcode_t'(ir[WIDTH-1 -: OPCODE_W]);
  assign operand     = ir[ADDR_W-1:0];
  assign operand_ext = {{(WIDTH-ADDR_W){1'b0}}, operand};
  assign halted      = (state == ST_HALT);

  // ALU: carry for ADD is the carry-out, for SUB it is "no borrow" (A >= B).
  assign alu_sum  = {1'b0, a} + {1'b0, b};
  assign alu_diff = {1'b0, a} - {1'b0, b};

  // Select ALU result and carry by opcode
  always_comb begin
    alu_result = alu_sum[WIDTH-1:0];
    alu_carry  = alu_sum[WIDTH];
    if (opcode == OP_SUB) begin
      alu_result = alu_diff[WIDTH-1:0];
      alu_carry  = ~alu_diff[WIDTH];
    end
  end

  // The write port belongs to program load while clr is high, otherwise to STA.
  assign sta_write = (state == ST_E2) && (opcode == OP_STA);
  assign ram_we    = clr ? prog_we   : sta_write;
  assign ram_waddr = clr ? prog_addr : mar;
  assign ram_wdata = clr ? prog_data : a;

  sap_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar),
    .rdata (ram_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= ST_F1;
    else     state <= state_next;
  end

  // Next-state: instructions leave for F1 as soon as their last step is done
  always_comb begin
    state_next = state;
    case (state)
      ST_F1: state_next = ST_F2;
      ST_F2: state_next = ST_E1;
      ST_E1: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: state_next = ST_E2;
          OP_HLT:                         state_next = ST_HALT;
          default:                        state_next = ST_F1;
        endcase
      end
      ST_E2: begin
        if (opcode == OP_ADD || opcode == OP_SUB) state_next = ST_E3;
        else                                      state_next = ST_F1;
      end
      ST_E3:   state_next = ST_F1;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_F1;
    endcase
  end

  // Datapath registers, updated according to the current T-state
  always_ff @(posedge clk) begin
    if (clr) begin
      pc        <= '0;
      mar       <= '0;
      ir        <= '0;
      a         <= '0;
      b         <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_F1: mar <= pc;
        ST_F2: begin
          ir <= ram_rdata;
          pc <= pc + ADDR_W'(1);
        end
        ST_E1: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
            OP_LDI: a  <= operand_ext;
            OP_JMP: pc <= operand;
            OP_JC:  if (c) pc <= operand;
            OP_JZ:  if (z) pc <= operand;
            OP_OUT: begin
              out       <= a;
              out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_E2: begin
          case (opcode)
            OP_LDA:         a <= ram_rdata;
            OP_ADD, OP_SUB: b <= ram_rdata;
            default: ;
          endcase
        end
        ST_E3: begin
          a <= alu_result;
          z <= (alu_result == '0);
          c <= alu_carry;
        end
        default: ;
      endcase
    end
  end

  // Bus view: whichever source the current T-state drives, else zero
  always_comb begin
    bus = '0;
    case (state)
      ST_F1: bus = {{(WIDTH-ADDR_W){1'b0}}, pc};
      ST_F2: bus = ram_rdata;
      ST_E1: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA,
          OP_LDI, OP_JMP, OP_JC, OP_JZ: bus = operand_ext;
          OP_OUT:                       bus = a;
          default:                      bus = '0;
        endcase
      end
      ST_E2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: bus = ram_rdata;
          OP_STA:                 bus = a;
          default:                bus = '0;
        endcase
      end
      ST_E3:   bus = alu_result;
      default: bus = '0;
    endcase
  end

endmodule

// File: tb/tb_sap_core.sv
// Directed-program bench for sap_core. Expected OUT values are queued when a
// program starts; a monitor pops and compares on every out_valid pulse.
module tb_sap_core;

  localparam int WIDTH  = 8;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              clr;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [WIDTH-1:0]  prog_data;
  logic [WIDTH-1:0]  out;
  logic              out_valid;
  logic              halted;
  logic [WIDTH-1:0]  bus;

  logic [WIDTH-1:0]  exp_q[$];
  logic [WIDTH-1:0]  prog [16];
  int                checks   = 0;
  int                failures = 0;

  sap_core #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out       (out),
    .out_valid (out_valid),
    .halted    (halted),
    .bus       (bus)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every out_valid pulse must match the queue head
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected actual=0x%0h expected=no pulse", out);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          failures++;
          $display("FAIL out_value actual=0x%0h expected=0x%0h", out, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_prog();
    foreach (prog[i]) prog[i] = '0;
  endtask

  // Writes prog[0..n-1] into RAM while holding clr
  task automatic load(input int n);
    clr = 1'b1;
    for (int i = 0; i < n; i++) begin
      prog_we   = 1'b1;
      prog_addr = ADDR_W'(i);
      prog_data = prog[i];
      step(1);
    end
    prog_we = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input string name);
    int k = 0;
    while (halted !== 1'b1 && k < budget) begin
      step(1);
      k++;
    end
    check(name, halted, 1);
  endtask

  task automatic drain(input string name);
    step(3);
    check(name, exp_q.size(), 0);
  endtask

  task automatic load_add_prog();
    clear_prog();
    prog[0] = 8'h19; prog[1] = 8'h2A; prog[2] = 8'hE0; prog[3] = 8'hF0;
    prog[9] = 8'h1C; prog[10] = 8'h0E;
    load(16);
  endtask

  task automatic load_sub_prog(input logic [7:0] subtrahend);
    clear_prog();
    prog[0]  = 8'h55; prog[1]  = 8'h3D; prog[2]  = 8'h87; prog[3]  = 8'h53;
    prog[4]  = 8'hE0; prog[5]  = 8'hF0; prog[7]  = 8'hE0; prog[8]  = 8'h7A;
    prog[9]  = 8'hF0; prog[10] = 8'h59; prog[11] = 8'hE0; prog[12] = 8'hF0;
    prog[13] = subtrahend;
    load(16);
  endtask

  initial begin
    clr       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    step(2);

    // Reset state
    check("reset_out", out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_halted", halted, 0);
    check("reset_bus", bus, 0);

    // LDA 9, ADD A, OUT, HLT -> 0x1C + 0x0E = 0x2A, halted after 15 edges
    load_add_prog();
    exp_q.push_back(8'h2A);
    clr = 1'b0;
    check("t1_first_fetch_bus", bus, 0);
    step(14);
    check("t1_not_halted_at_14", halted, 0);
    step(1);
    check("t1_halted_at_15", halted, 1);
    step(4);
    check("t1_halt_hold", halted, 1);
    check("t1_out_hold", out, 8'h2A);
    check("t1_halt_bus", bus, 0);
    drain("t1_queue_empty");

    // SUB 5-5 -> Z=1,C=1: JZ 7 taken, OUT 0, then JC taken, OUT 9
    load_sub_prog(8'h05);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h09);
    clr = 1'b0;
    step(11);
    check("t2_jz_taken_pc", bus, 7);
    wait_halt(100, "t2_halt");
    drain("t2_queue_empty");

    // SUB 5-3 -> Z=0: JZ falls through to LDI 3, OUT 3
    load_sub_prog(8'h03);
    exp_q.push_back(8'h03);
    clr = 1'b0;
    step(11);
    check("t2b_jz_not_taken_pc", bus, 3);
    wait_halt(100, "t2b_halt");
    drain("t2b_queue_empty");

    // LDI F, ADD 0xF2 -> A=0x01, C=1, Z=0; JC taken, JZ not taken
    clear_prog();
    prog[0]  = 8'h5F; prog[1]  = 8'h2F; prog[2]  = 8'hE0; prog[3]  = 8'h76;
    prog[4]  = 8'h57; prog[5]  = 8'hE0; prog[6]  = 8'h5C; prog[7]  = 8'hE0;
    prog[8]  = 8'h8B; prog[9]  = 8'hF0; prog[11] = 8'h51; prog[12] = 8'hE0;
    prog[13] = 8'hF0; prog[15] = 8'hF2;
    load(16);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h0C);
    clr = 1'b0;
    step(7);
    check("t3_alu_bus_e3", bus, 8'h01);
    step(7);
    check("t3_jc_taken_pc", bus, 6);
    wait_halt(100, "t3_halt");
    drain("t3_queue_empty");

    // LDI B, STA E, LDI 0, LDA E, OUT -> 0x0B
    clear_prog();
    prog[0] = 8'h5B; prog[1] = 8'h4E; prog[2] = 8'h50;
    prog[3] = 8'h1E; prog[4] = 8'hE0; prog[5] = 8'hF0;
    load(16);
    exp_q.push_back(8'h0B);
    clr = 1'b0;
    step(6);
    check("t4_sta_bus_a", bus, 8'h0B);
    wait_halt(100, "t4_halt");
    drain("t4_queue_empty");

    // RAM[E] survives clr: reload only words 0..2 with LDA E, OUT, HLT
    prog[0] = 8'h1E; prog[1] = 8'hE0; prog[2] = 8'hF0;
    load(3);
    check("t4b_out_cleared", out, 0);
    exp_q.push_back(8'h0B);
    clr = 1'b0;
    wait_halt(100, "t4b_halt");
    drain("t4b_queue_empty");

    // 16 NOPs: PC walks 0..15 and wraps to 0, no output
    clear_prog();
    load(16);
    clr = 1'b0;
    check("t5_pc0", bus, 0);
    step(3);
    check("t5_pc1", bus, 1);
    step(42);
    check("t5_pc15", bus, 15);
    step(3);
    check("t5_pc_wrap", bus, 0);
    step(20);
    check("t5_out_unchanged", out, 0);
    check("t5_not_halted", halted, 0);
    drain("t5_queue_empty");

    // clr during E2 of ADD, then during HALT
    load_add_prog();
    clr = 1'b0;
    step(7);
    check("t6_add_e2_bus", bus, 8'h0E);
    clr = 1'b1;
    step(1);
    check("t6_midclr_out", out, 0);
    check("t6_midclr_halted", halted, 0);
    check("t6_midclr_bus_pc0", bus, 0);
    exp_q.push_back(8'h2A);
    clr = 1'b0;
    wait_halt(100, "t6_halt");
    drain("t6_queue_empty");
    clr = 1'b1;
    step(1);
    check("t6_haltclr_halted", halted, 0);
    check("t6_haltclr_out", out, 0);
    check("t6_haltclr_out_valid", out_valid, 0);
    exp_q.push_back(8'h2A);
    clr = 1'b0;
    check("t6_refetch_pc0", bus, 0);
    step(1);
    check("t6_refetch_ir_bus", bus, 8'h19);
    step(1);
    check("t6_refetch_operand", bus, 9);
    wait_halt(100, "t6b_halt");
    drain("t6b_queue_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap_core.md
SAP_CORE -- requirements
Module: sap_core

Interface
REQ-001 Parameter WIDTH, default 8, data/accumulator/bus width; SHALL satisfy WIDTH >= 4 + ADDR_W.
REQ-002 Parameter ADDR_W, default 4, RAM address width; RAM depth SHALL be 2**ADDR_W words of WIDTH bits.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 clr  input  1  reset; synchronous and active-high.
REQ-005 prog_we  input  1  RAM write strobe, honoured only while clr=1.
REQ-006 prog_addr  input  ADDR_W  program-load address.
REQ-007 prog_data  input  WIDTH  program-load data.
REQ-008 out  output  WIDTH  output register, holds last OUT value.
REQ-009 out_valid  output  1  one-cycle pulse in the cycle out updates.
REQ-010 halted  output  1  high while in HALT state.
REQ-011 bus  output  WIDTH  value on internal bus this cycle, 0 when undriven.

Function
REQ-012 Instruction word: opcode = bits [WIDTH-1:WIDTH-4], operand = bits [ADDR_W-1:0]; other bits ignored.
REQ-013 Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 STA, 5 LDI, 6 JMP, 7 JC, 8 JZ, E OUT, F HLT; all others execute as NOP.
REQ-014 States: F1, F2, E1, E2, E3, HALT; instructions end early by returning to F1 (variable-length T-cycle, unlike fixed ring counter).
REQ-015 F1: MAR <= PC. F2: IR <= RAM[MAR], PC <= PC+1 mod 2**ADDR_W.
REQ-016 LDA: E1 MAR <= operand; E2 A <= RAM[MAR] -> F1 (4 cycles total).
REQ-017 ADD/SUB: E1 MAR <= operand; E2 B <= RAM[MAR]; E3 A <= A+B or A-B (mod 2**WIDTH), flags updated -> F1 (5 cycles).
REQ-018 STA: E1 MAR <= operand; E2 RAM[MAR] <= A -> F1 (4 cycles).
REQ-019 LDI: E1 A <= zero-extended operand -> F1 (3 cycles).
REQ-020 JMP: E1 PC <= operand. JC/JZ: E1 PC <= operand only if C/Z set, else PC unchanged -> F1 (3 cycles).
REQ-021 OUT: E1 out <= A, out_valid=1 that cycle -> F1 (3 cycles); out_valid=0 at all other times.
REQ-022 HLT: E1 -> HALT; HALT is terminal, halted=1, no register or RAM changes until clr.
REQ-023 NOP: E1 -> F1 (3 cycles).
REQ-024 Flags: Z = (result==0); C = carry-out for ADD, C = no-borrow (A>=B unsigned) for SUB; only ADD/SUB modify flags.
REQ-025 RAM read is combinational on MAR; RAM write is synchronous; program write and STA never coincide (STA impossible during clr).
REQ-026 PC wrap: PC = 2**ADDR_W-1 fetch SHALL advance PC to 0.
REQ-027 bus shows PC in F1, RAM[MAR] in F2/E2 reads, operand in E1 address/LDI/jump, A in STA E2/OUT E1, ALU result in E3; else 0.

Reset
REQ-028 clr=1 at a clock edge SHALL set PC, MAR, IR, A, B, Z, C, out to 0, out_valid=0, state=F1, halted=0, from any state incl. mid-instruction and HALT.
REQ-029 RAM contents SHALL NOT be cleared by clr; prog_we writes occur on the same edges while clr=1.
REQ-030 First fetch (F1) SHALL occur on the first edge with clr=0.

Structure
REQ-031 Package sap_pkg holds opcode constants and the state enumeration.
REQ-032 RAM SHALL be sub-module sap_ram (params WIDTH, ADDR_W; one sync write port muxed between program load and STA, one async read port).

Verification
REQ-033 Load {LDA 9, ADD A, OUT, HLT} with RAM[9]=0x1C, RAM[A]=0x0E -> out=0x2A with one out_valid pulse, halted=1 after 15 cycles post-clr.
REQ-034 SUB 5-5 then JZ 7 to OUT -> Z=1, C=1, jump taken, out=0x00; with unequal operands JZ not taken, PC sequential.
REQ-035 LDI 0xF, ADD of 0xF2 -> A=0x01, C=1, Z=0; following JC taken.
REQ-036 STA 0xE then LDA 0xE then OUT -> out equals stored A; RAM[0xE] persists across a later clr.
REQ-037 Program of 16 NOPs -> PC wraps to 0, fetch continues at address 0, out unchanged, out_valid never asserted.
REQ-038 Assert clr during E2 of ADD and again while halted -> all registers 0, state F1, next fetch from address 0.
